// File: rtl/mux_sel_sequencer.sv
// Control stage for an external 8:1 bit-select mux: latches a word, walks sel
// across its bits on each bit_en strobe and registers the returned bit serially.
module mux_sel_sequencer #(
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_BITS   = 1,
    parameter bit          IDLE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       bit_en,
    output logic [7:0] data_out,
    output logic [2:0] sel,
    input  logic       mux_bit,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_last,
    output logic       busy
);

    localparam int unsigned SEL_W = 3;
    localparam int unsigned GAP_W = 4;
    localparam logic [SEL_W-1:0] START_IDX = MSB_FIRST ? SEL_W'(7) : SEL_W'(0);
    localparam logic [SEL_W-1:0] LAST_IDX  = MSB_FIRST ? SEL_W'(0) : SEL_W'(7);
    localparam logic [GAP_W-1:0] GAP_INIT  = GAP_W'(GAP_BITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               ser_q, ser_d;
    logic               ser_valid_q, ser_valid_d;
    logic               ser_last_q, ser_last_d;
    logic               busy_q, busy_d;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        sel_d       = sel_q;
        gap_d       = gap_q;
        ser_d       = ser_q;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    sel_d   = START_IDX;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_en) begin
                    ser_d       = mux_bit;
                    ser_valid_d = 1'b1;
                    if (sel_q == LAST_IDX) begin
                        ser_last_d = 1'b1;
                        sel_d      = START_IDX;
                        if (GAP_BITS > 0) begin
                            state_d = S_GAP;
                            gap_d   = GAP_INIT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (MSB_FIRST) begin
                        sel_d = SEL_W'(sel_q - SEL_W'(1));
                    end else begin
                        sel_d = SEL_W'(sel_q + SEL_W'(1));
                    end
                end
            end
            S_GAP: begin
                if (bit_en) begin
                    ser_d = IDLE_LEVEL;
                    gap_d = GAP_W'(gap_q - GAP_W'(1));
                    if (gap_q <= GAP_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            data_q      <= 8'h00;
            sel_q       <= START_IDX;
            gap_q       <= '0;
            ser_q       <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            gap_q       <= gap_d;
            ser_q       <= ser_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign data_out  = data_q;
    assign sel       = sel_q;
    assign ser_out   = ser_q;
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: two configurations on shared stimulus, a
// period-counting reference model, a directed vector table and corner sequences.
module tb_mux_sel_sequencer;

    localparam int G0 = 1;
    localparam int G1 = 3;

    logic clk = 1'b0;
    logic rst, in_valid, bit_en;
    logic [7:0] in_data;

    logic [1:0]       rdy, ser, sv, sl, bsy, mb;
    logic [1:0][7:0]  dout;
    logic [1:0][2:0]  sel;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign mb[0] = dout[0][sel[0]];
    assign mb[1] = dout[1][sel[1]];

    mux_sel_sequencer #(.MSB_FIRST(1'b0), .GAP_BITS(G0), .IDLE_LEVEL(1'b1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .bit_en(bit_en), .data_out(dout[0]), .sel(sel[0]), .mux_bit(mb[0]),
        .ser_out(ser[0]), .ser_valid(sv[0]), .ser_last(sl[0]), .busy(bsy[0]));

    mux_sel_sequencer #(.MSB_FIRST(1'b1), .GAP_BITS(G1), .IDLE_LEVEL(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .bit_en(bit_en), .data_out(dout[1]), .sel(sel[1]), .mux_bit(mb[1]),
        .ser_out(ser[1]), .ser_valid(sv[1]), .ser_last(sl[1]), .busy(bsy[1]));

    // Reference model: each word occupies 8+GAP bit periods after acceptance
    int         rem[2];
    logic [7:0] m_word[2];
    logic       m_ser[2], m_sv[2], m_sl[2];

    function automatic int gap_of(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    function automatic int pos_of(input int i, input int idx);
        return (i == 0) ? idx : 7 - idx;
    endfunction

    function automatic int exp_sel(input int i);
        if (rem[i] > gap_of(i)) return pos_of(i, 8 + gap_of(i) - rem[i]);
        return pos_of(i, 0);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_sv[i] = 1'b0;
            m_sl[i] = 1'b0;
            if (rst) begin
                rem[i] = 0;
                m_word[i] = 8'h00;
                m_ser[i] = (i == 0);
            end else if (rem[i] == 0) begin
                if (in_valid) begin
                    m_word[i] = in_data;
                    rem[i] = 8 + gap_of(i);
                end
            end else if (bit_en) begin
                if (rem[i] > gap_of(i)) begin
                    int idx;
                    idx = 8 + gap_of(i) - rem[i];
                    m_ser[i] = m_word[i][pos_of(i, idx)];
                    m_sv[i] = 1'b1;
                    m_sl[i] = (idx == 7);
                end else begin
                    m_ser[i] = (i == 0);
                end
                rem[i] = rem[i] - 1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d_ser", i), 32'(ser[i]), 32'(m_ser[i]));
            chk($sformatf("m%0d_sv", i), 32'(sv[i]), 32'(m_sv[i]));
            chk($sformatf("m%0d_sl", i), 32'(sl[i]), 32'(m_sl[i]));
            chk($sformatf("m%0d_rdy", i), 32'(rdy[i]), 32'(rem[i] == 0));
            chk($sformatf("m%0d_busy", i), 32'(bsy[i]), 32'(rem[i] != 0));
            chk($sformatf("m%0d_dout", i), 32'(dout[i]), 32'(m_word[i]));
            chk($sformatf("m%0d_sel", i), 32'(sel[i]), 32'(exp_sel(i)));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; bit_en = 1'b0; in_data = 8'h00;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst, vld, ben;
        logic [7:0] din, e_dout;
        logic [2:0] e_sel;
        logic       e_ser, e_sv, e_sl, e_rdy, e_busy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [7:0] w, pat;
        int cnt;

        rst = 1'b1; in_valid = 1'b0; bit_en = 1'b0; in_data = 8'h00;

        // LSB-first word 0xB2 on u0, bit_en high
        w = 8'hB2;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, w,     w,     3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 1; k <= 8; k++)
            tbl[2+k] = '{1'b0, 1'b0, 1'b1, 8'h00, w, 3'(k % 8), w[k-1], 1'b1, (k == 8), 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h00, w, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        for (int r = 0; r < 12; r++) begin
            rst = tbl[r].rst; in_valid = tbl[r].vld; bit_en = tbl[r].ben; in_data = tbl[r].din;
            cycle();
            chk($sformatf("t%0d_ser", r), 32'(ser[0]), 32'(tbl[r].e_ser));
            chk($sformatf("t%0d_sv", r), 32'(sv[0]), 32'(tbl[r].e_sv));
            chk($sformatf("t%0d_sl", r), 32'(sl[0]), 32'(tbl[r].e_sl));
            chk($sformatf("t%0d_sel", r), 32'(sel[0]), 32'(tbl[r].e_sel));
            chk($sformatf("t%0d_rdy", r), 32'(rdy[0]), 32'(tbl[r].e_rdy));
            chk($sformatf("t%0d_busy", r), 32'(bsy[0]), 32'(tbl[r].e_busy));
            chk($sformatf("t%0d_dout", r), 32'(dout[0]), 32'(tbl[r].e_dout));
        end

        // MSB-first 0xA5 on u1: sel walks 7..0
        do_reset();
        pat = 8'b1010_0101;
        in_valid = 1'b1; in_data = 8'hA5; bit_en = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("msb_ser", 32'(ser[1]), 32'(pat[7-k]));
            chk("msb_sv", 32'(sv[1]), 32'd1);
            chk("msb_sl", 32'(sl[1]), 32'(k == 7));
            chk("msb_sel", 32'(sel[1]), (k < 7) ? 32'(6 - k) : 32'd7);
        end

        // Strobe every 4th cycle, 0x81 on u0
        do_reset();
        in_valid = 1'b1; in_data = 8'h81; bit_en = 1'b0;
        cycle();
        in_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            logic [2:0] prev;
            prev = sel[0];
            bit_en = ((c % 4) == 3);
            cycle();
            if (sv[0]) cnt++;
            if (!bit_en) chk("strb_hold", 32'(sel[0]), 32'(prev));
            if (c == 31) chk("strb_last", 32'(sl[0]), 32'd1);
        end
        chk("strb_count", 32'(cnt), 32'd8);
        chk("strb_idle", 32'(bsy[0]), 32'd0);

        // in_valid held with changing data during the word
        do_reset();
        in_valid = 1'b1; in_data = 8'h3C; bit_en = 1'b1;
        cycle();
        for (int c = 1; c <= 9; c++) begin
            in_data = 8'($urandom);
            cycle();
            chk("hold_dout", 32'(dout[0]), 32'h3C);
            chk("hold_rdy", 32'(rdy[0]), 32'(c == 9));
        end
        in_data = 8'h5A;
        cycle();
        chk("hold_next", 32'(dout[0]), 32'h5A);
        in_valid = 1'b0;

        // Reset after bit 3 of 0xFF aborts the word
        do_reset();
        in_valid = 1'b1; in_data = 8'hFF; bit_en = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("abort_ser", 32'(ser[0]), 32'd1);
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        chk("abort_sel", 32'(sel[0]), 32'd0);
        chk("abort_sel1", 32'(sel[1]), 32'd7);
        chk("abort_ser1", 32'(ser[1]), 32'd0);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (sv[0] || sv[1]) cnt++;
        end
        chk("abort_quiet", 32'(cnt), 32'd0);
        in_valid = 1'b1; in_data = 8'h01;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("restart_ser", 32'(ser[0]), 32'd1);
        chk("restart_sv", 32'(sv[0]), 32'd1);
        chk("restart_sel", 32'(sel[0]), 32'd1);

        // Randomised traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            in_valid = 1'($urandom);
            in_data = 8'($urandom);
            bit_en = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream control stage for the team's 8:1 bit-select mux (ports sel[2:0], a[7:0], single-bit output).
- Accepts an 8-bit word over a valid/ready handshake and holds it on `data_out` (wired to the mux `a`).
- Steps `sel` through the 8 indices, one index per `bit_en` strobe, and registers the returned mux bit onto a serial output.
- An optional inter-word gap of idle-level bits follows each word.

Parameters:
- MSB_FIRST, 0 — 0: sel order 0→7; 1: sel order 7→0.
- GAP_BITS, 1 — number of idle bit periods after each word; legal range 0..15.
- IDLE_LEVEL, 1 — `ser_out` level when idle, during gap, and after reset.

Ports:
- clk  in  1  — clock; all state updates on the rising edge.
- rst  in  1  — synchronous, active-high reset.
- in_valid  in  1  — upstream word valid.
- in_ready  out  1  — block can accept a word.
- in_data  in  8  — word to serialise.
- bit_en  in  1  — bit-period strobe (baud tick); may be tied high.
- data_out  out  8  — latched word; drives mux `a`.
- sel  out  3  — mux select; drives mux `sel`.
- mux_bit  in  1  — mux output, combinationally equal to data_out[sel].
- ser_out  out  1  — registered serial bit.
- ser_valid  out  1  — 1-cycle pulse when ser_out takes a new data bit.
- ser_last  out  1  — high with ser_valid on the 8th bit of a word.
- busy  out  1  — high in SHIFT or GAP.

Behaviour:
- Reset values, applied at the edge where rst=1:
  - State IDLE; sel = MSB_FIRST ? 7 : 0; data_out = 0.
  - ser_out = IDLE_LEVEL; ser_valid = 0; ser_last = 0; gap counter = 0.
- Reset wins over every other event.
- Reset mid-word or mid-gap aborts the word; the remaining bits are discarded and never emitted.
- in_ready = (state == IDLE). It is combinational from state only and is 1 in the cycle after reset.
- State IDLE:
  - Accept on an edge with in_valid & in_ready: data_out <= in_data, sel <= start index, state <= SHIFT.
  - bit_en is ignored in IDLE; ser_out holds IDLE_LEVEL.
- State SHIFT, on an edge with bit_en=1:
  - ser_out <= mux_bit (the bit for the current sel); ser_valid <= 1.
  - ser_last <= 1 if sel is the final index (7, or 0 when MSB_FIRST), else 0.
  - If not at the final index: sel steps by ±1.
  - At the final index: sel <= start index. Then state <= GAP with gap counter = GAP_BITS if GAP_BITS > 0, else state <= IDLE.
- State SHIFT, on an edge with bit_en=0: sel and ser_out hold; ser_valid = 0; ser_last = 0.
- In SHIFT, data_out holds constant for the whole word. in_valid changes and new in_data are ignored.
- Latency:
  - The accept edge is E0. The first data bit appears on ser_out after the first bit_en edge following E0.
  - With bit_en tied high, bit k (k = 0..7 in sel order) is on ser_out after edge E0+1+k.
- State GAP:
  - The first bit_en edge sets ser_out <= IDLE_LEVEL. Every bit_en edge decrements the gap counter; ser_valid stays 0.
  - When the counter reaches 0, state <= IDLE.
  - Net effect: GAP_BITS idle bit periods.
- Back-to-back words: with GAP_BITS = 0 and bit_en tied high, the next accept occurs at E0+9. One IDLE cycle separates words, during which ser_out holds the last data bit.
- busy = (state != IDLE), registered with the state.
- sel width is exactly 3 bits; no wrap occurs outside the final-index handling.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 → sel=0, data_out=0, ser_out=1, in_ready=1, busy=0, ser_valid=0.
- LSB-first, bit_en=1, GAP_BITS=1, in_data=8'b1011_0010 accepted at E0:
  - ser_out sequence after E1..E8 is 0,1,0,0,1,1,0,1.
  - ser_valid is high 8 cycles; ser_last is high only after E8.
  - ser_out=1 after E9; in_ready=1 after E9.
- MSB_FIRST=1, in_data=8'hA5 → sel goes 7..0; ser_out is 1,0,1,0,0,1,0,1; ser_last aligned with sel=0.
- bit_en=1 every 4th cycle, in_data=8'h81:
  - sel advances only on strobes; ser_out holds between strobes.
  - ser_valid fires exactly 8 times, total 32 cycles.
- in_valid held high with changing in_data during SHIFT → data_out is unchanged; in_ready=0 until IDLE; the second word is accepted only after the gap completes.
- rst asserted after bit 3 of 8'hFF → next edge: ser_out=IDLE_LEVEL, busy=0, sel=0. No further ser_valid pulses occur, and a new word starts cleanly at bit 0.
